// File: rtl/axi_llc_pkg.sv
// Shared LLC types: static configuration, AXI widths, cache-unit tags
// and default payload types for standalone elaboration of the refill path.
package axi_llc_pkg;

    typedef struct packed {
        int unsigned NumWays;
        int unsigned NumBlocks;
        int unsigned BlockOffsetLength;
        int unsigned ByteOffsetLength;
        int unsigned IndexLength;
    } llc_cfg_t;

    typedef struct packed {
        int unsigned AddrWidthFull;
        int unsigned DataWidthFull;
    } llc_axi_cfg_t;

    typedef enum logic [1:0] {
        EvictUnit = 2'd0,
        RefilUnit = 2'd1,
        RwUnit    = 2'd2
    } cache_unit_e;

    localparam llc_cfg_t DefaultCfg = '{
        NumWays:           4,
        NumBlocks:         8,
        BlockOffsetLength: 3,
        ByteOffsetLength:  3,
        IndexLength:       8
    };

    localparam llc_axi_cfg_t DefaultAxiCfg = '{
        AddrWidthFull: 32,
        DataWidthFull: 64
    };

    typedef struct packed {
        logic        refill;
        logic [3:0]  way_ind;
        logic [31:0] a_x_addr;
    } llc_desc_t;

    typedef struct packed {
        cache_unit_e cache_unit;
        logic [3:0]  way_ind;
        logic [7:0]  line_addr;
        logic [2:0]  blk_offset;
        logic        we;
        logic [63:0] data;
        logic [7:0]  strb;
    } llc_way_inp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } llc_r_chan_t;

endpackage

// File: rtl/axi_llc_sync_fifo.sv
// Fall-through synchronous FIFO: a push into an empty FIFO is visible
// on data_o in the same cycle and may be popped straight through.
module axi_llc_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dtype data_i,
    output logic full_o,
    input  logic pop_i,
    output dtype data_o,
    output logic empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [AW-1:0] ptr_t;

    dtype           mem_q [DEPTH];
    ptr_t           wptr_q;
    ptr_t           rptr_q;
    logic [CW-1:0]  usage_q;
    logic           stored_empty;
    logic           bypass;
    logic           do_write;
    logic           do_read;

    function automatic ptr_t nxt(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign stored_empty = (usage_q == '0);
    assign full_o       = (usage_q == CW'(DEPTH));
    assign empty_o      = stored_empty & ~push_i;
    assign data_o       = stored_empty ? data_i : mem_q[rptr_q];
    assign bypass       = stored_empty & push_i & pop_i;
    assign do_write     = push_i & ~bypass;
    assign do_read      = pop_i & ~stored_empty;

    // Storage array; contents need no reset since usage gates reads.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            if (do_write) begin
                wptr_q <= nxt(wptr_q);
            end
            if (do_read) begin
                rptr_q <= nxt(rptr_q);
            end
            usage_q <= usage_q + CW'(do_write) - CW'(do_read);
        end
    end

endmodule

// File: rtl/axi_llc_r_refill.sv
// Refill R path: collects one cache line of R beats for a refill
// descriptor, writes it block-wise into the data ways, then forwards it.
module axi_llc_r_refill
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t     Cfg       = DefaultCfg,
    parameter llc_axi_cfg_t AxiCfg    = DefaultAxiCfg,
    parameter type          desc_t    = llc_desc_t,
    parameter type          way_inp_t = llc_way_inp_t,
    parameter type          r_chan_t  = llc_r_chan_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  desc_t    desc_i,
    input  logic     desc_valid_i,
    output logic     desc_ready_o,
    output desc_t    desc_o,
    output logic     desc_valid_o,
    input  logic     desc_ready_i,
    input  r_chan_t  r_chan_mst_i,
    input  logic     r_chan_valid_i,
    output logic     r_chan_ready_o,
    output way_inp_t way_inp_o,
    output logic     way_inp_valid_o,
    input  logic     way_inp_ready_i,
    output logic     resp_err_o,
    output logic     last_err_o
);

    localparam int unsigned NumBlocks = Cfg.NumBlocks;
    localparam int unsigned LineLsb   = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength;

    typedef logic [Cfg.BlockOffsetLength-1:0] offset_t;
    typedef logic [AxiCfg.DataWidthFull-1:0]  data_t;

    localparam offset_t LastBlk = offset_t'(NumBlocks - 1);

    desc_t   desc_q;
    logic    busy_q;
    logic    send_q;
    offset_t r_cnt_q;
    offset_t w_cnt_q;
    logic    r_done_q;
    logic    resp_err_q;
    logic    last_err_q;

    logic    s_refill;
    logic    s_send;
    logic    s_idle;
    logic    r_hs;
    logic    w_hs;
    logic    load;
    logic    fifo_full;
    logic    fifo_empty;
    data_t   fifo_data;
    logic    unused_bits;

    // The flag pair 11 is never entered; it decodes as idle.
    assign s_refill = busy_q & ~send_q;
    assign s_send   = send_q & ~busy_q;
    assign s_idle   = ~(s_refill | s_send);

    assign desc_ready_o    = s_idle | (s_send & desc_ready_i);
    assign desc_valid_o    = s_send;
    assign desc_o          = desc_q;
    assign r_chan_ready_o  = s_refill & ~fifo_full & ~r_done_q;
    assign way_inp_valid_o = s_refill & ~fifo_empty;
    assign resp_err_o      = resp_err_q;
    assign last_err_o      = last_err_q;

    assign load = desc_valid_i & desc_ready_o;
    assign r_hs = r_chan_valid_i & r_chan_ready_o;
    assign w_hs = way_inp_valid_o & way_inp_ready_i;

    assign unused_bits = ^{r_chan_mst_i, desc_q};

    axi_llc_sync_fifo #(
        .DEPTH (NumBlocks),
        .dtype (data_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (r_hs),
        .data_i  (r_chan_mst_i.data),
        .full_o  (fifo_full),
        .pop_i   (w_hs),
        .data_o  (fifo_data),
        .empty_o (fifo_empty)
    );

    // Data way write request built from the held descriptor and FIFO head.
    always_comb begin
        way_inp_o            = '0;
        way_inp_o.cache_unit = RefilUnit;
        way_inp_o.way_ind    = desc_q.way_ind;
        way_inp_o.line_addr  = desc_q.a_x_addr[LineLsb +: Cfg.IndexLength];
        way_inp_o.blk_offset = w_cnt_q;
        way_inp_o.we         = 1'b1;
        way_inp_o.data       = fifo_data;
        way_inp_o.strb       = '1;
    end

    // Control flags, beat/block counters and registered error pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            desc_q     <= '0;
            busy_q     <= 1'b0;
            send_q     <= 1'b0;
            r_cnt_q    <= '0;
            w_cnt_q    <= '0;
            r_done_q   <= 1'b0;
            resp_err_q <= 1'b0;
            last_err_q <= 1'b0;
        end else begin
            resp_err_q <= r_hs & r_chan_mst_i.resp[1];
            last_err_q <= r_hs & (r_chan_mst_i.last != (r_cnt_q == LastBlk));
            if (r_hs) begin
                r_cnt_q <= r_cnt_q + offset_t'(1);
                if (r_cnt_q == LastBlk) begin
                    r_done_q <= 1'b1;
                end
            end
            if (w_hs) begin
                w_cnt_q <= w_cnt_q + offset_t'(1);
                if (w_cnt_q == LastBlk) begin
                    busy_q <= 1'b0;
                    send_q <= 1'b1;
                end
            end
            if (s_send && desc_ready_i) begin
                send_q <= 1'b0;
            end
            if (load) begin
                desc_q <= desc_i;
                if (desc_i.refill) begin
                    busy_q   <= 1'b1;
                    send_q   <= 1'b0;
                    r_cnt_q  <= '0;
                    w_cnt_q  <= '0;
                    r_done_q <= 1'b0;
                end else begin
                    busy_q <= 1'b0;
                    send_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_llc_r_refill.sv
// Directed bench for the refill R path: descriptor table plus
// hand-written timing, back-pressure, error and reset sequences.
module tb_axi_llc_r_refill;
    import axi_llc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    llc_desc_t    desc_i;
    logic         desc_valid_i;
    logic         desc_ready_o;
    llc_desc_t    desc_o;
    logic         desc_valid_o;
    logic         desc_ready_i;
    llc_r_chan_t  r_beat;
    logic         r_valid;
    logic         r_ready;
    llc_way_inp_t way_inp;
    logic         way_valid;
    logic         way_ready;
    logic         resp_err;
    logic         last_err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    llc_way_inp_t wq[$];

    typedef struct {
        logic        refill;
        logic [3:0]  way;
        logic [31:0] addr;
        logic [7:0]  line;
        int          writes;
        logic [63:0] base;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    axi_llc_r_refill dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .desc_i          (desc_i),
        .desc_valid_i    (desc_valid_i),
        .desc_ready_o    (desc_ready_o),
        .desc_o          (desc_o),
        .desc_valid_o    (desc_valid_o),
        .desc_ready_i    (desc_ready_i),
        .r_chan_mst_i    (r_beat),
        .r_chan_valid_i  (r_valid),
        .r_chan_ready_o  (r_ready),
        .way_inp_o       (way_inp),
        .way_inp_valid_o (way_valid),
        .way_inp_ready_i (way_ready),
        .resp_err_o      (resp_err),
        .last_err_o      (last_err)
    );

    always @(negedge clk) begin
        if (way_valid && way_ready) wq.push_back(way_inp);
        if (resp_err || last_err) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic llc_desc_t mk(input logic refill, input logic [3:0] way,
                                     input logic [31:0] addr);
        llc_desc_t d;
        d = '0;
        d.refill = refill;
        d.way_ind = way;
        d.a_x_addr = addr;
        return d;
    endfunction

    task automatic load_desc(input llc_desc_t d);
        bit ok = 0;
        desc_i = d;
        desc_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (desc_ready_o) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
        check("desc_load", 64'(ok), 64'(1));
    endtask

    task automatic send_beats(input logic [63:0] base, input int n,
                              input int last_pos);
        for (int k = 0; k < n; k++) begin
            bit ok = 0;
            r_beat = '0;
            r_beat.data = base + 64'(k);
            r_beat.last = (k == last_pos);
            r_valid = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (r_ready) begin ok = 1; break; end
            end
            @(posedge clk); #1;
            check("r_accept", 64'(ok), 64'(1));
        end
        r_valid = 1'b0;
    endtask

    task automatic wait_desc_out(input llc_desc_t exp);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (desc_valid_o) begin ok = 1; break; end
        end
        check("desc_out_valid", 64'(ok), 64'(1));
        check("desc_out", 64'(desc_o), 64'(exp));
        desc_ready_i = 1'b1;
        @(posedge clk); #1;
        desc_ready_i = 1'b0;
    endtask

    task automatic check_writes(input int n, input logic [63:0] base,
                                input logic [7:0] line, input logic [3:0] way);
        check("n_writes", 64'(wq.size()), 64'(n));
        for (int k = 0; k < wq.size(); k++) begin
            check("blk_offset", 64'(wq[k].blk_offset), 64'(k));
            check("wr_data", wq[k].data, base + 64'(k));
            check("line_addr", 64'(wq[k].line_addr), 64'(line));
            check("way_ind", 64'(wq[k].way_ind), 64'(way));
            check("we_strb", 64'({wq[k].we, wq[k].strb}), 64'(9'h1FF));
            check("cache_unit", 64'(wq[k].cache_unit), 64'(RefilUnit));
        end
        wq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        llc_desc_t d;
        err_cnt = 0;
        d = mk(v.refill, v.way, v.addr);
        load_desc(d);
        if (v.refill) send_beats(v.base, 8, 7);
        wait_desc_out(d);
        check_writes(v.writes, v.base, v.line, v.way);
        check("err_pulses", 64'(err_cnt), 64'(0));
    endtask

    initial begin
        llc_desc_t d;
        llc_desc_t d2;
        logic [63:0] base;
        int acc;

        desc_i = '0;
        desc_valid_i = 1'b0;
        desc_ready_i = 1'b0;
        r_beat = '0;
        r_valid = 1'b0;
        way_ready = 1'b1;

        vecs[0] = '{1'b1, 4'b0001, 32'h0000_1240, 8'h49, 8, 64'h0000_0000_0000_A000};
        vecs[1] = '{1'b0, 4'b0010, 32'h1234_5678, 8'h59, 0, 64'h0};
        vecs[2] = '{1'b1, 4'b1000, 32'hFFFF_FFC0, 8'hFF, 8, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[3] = '{1'b1, 4'b0100, 32'h1234_5678, 8'h59, 8, 64'h5555_0000_0000_0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_desc_ready", 64'(desc_ready_o), 64'(1));
        check("rst_desc_valid", 64'(desc_valid_o), 64'(0));
        check("rst_r_ready", 64'(r_ready), 64'(0));
        check("rst_way_valid", 64'(way_valid), 64'(0));
        check("rst_errs", 64'({resp_err, last_err}), 64'(0));
        @(posedge clk); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Back-to-back beats: each block written in its beat's cycle.
        d = mk(1'b1, 4'b0010, 32'h0000_0080);
        base = 64'hC0DE_0000_0000_0000;
        load_desc(d);
        for (int k = 0; k < 8; k++) begin
            r_beat = '0;
            r_beat.data = base + 64'(k);
            r_beat.last = (k == 7);
            r_valid = 1'b1;
            @(negedge clk);
            check("a_r_ready", 64'(r_ready), 64'(1));
            check("a_way_valid", 64'(way_valid), 64'(1));
            check("a_blk_offset", 64'(way_inp.blk_offset), 64'(k));
            check("a_data", way_inp.data, base + 64'(k));
            check("a_desc_valid", 64'(desc_valid_o), 64'(0));
            @(posedge clk); #1;
        end
        r_valid = 1'b0;
        @(negedge clk);
        check("a_desc_valid_after", 64'(desc_valid_o), 64'(1));
        check("a_way_idle", 64'(way_valid), 64'(0));
        wait_desc_out(d);
        check_writes(8, base, 8'h02, 4'b0010);

        // Way stalled: FIFO fills to a full line, then drains in order.
        way_ready = 1'b0;
        d = mk(1'b1, 4'b1000, 32'h0000_3FC0);
        base = 64'h0123_4567_89AB_CD00;
        load_desc(d);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            bit hs = 0;
            r_beat = '0;
            r_beat.data = base + 64'(acc);
            r_beat.last = (acc == 7);
            r_valid = 1'b1;
            @(negedge clk);
            hs = r_ready;
            @(posedge clk); #1;
            if (hs) acc++;
        end
        r_valid = 1'b0;
        check("b_beats_buffered", 64'(acc), 64'(8));
        @(negedge clk);
        check("b_r_ready_low", 64'(r_ready), 64'(0));
        check("b_head_valid", 64'(way_valid), 64'(1));
        check("b_head_data", way_inp.data, base);
        check("b_no_writes", 64'(wq.size()), 64'(0));
        way_ready = 1'b1;
        wait_desc_out(d);
        check_writes(8, base, 8'hFF, 4'b1000);

        // Pass-through descriptors forwarded back to back.
        d = mk(1'b0, 4'b0001, 32'hDEAD_BEC0);
        d2 = mk(1'b0, 4'b0100, 32'h0BAD_F000);
        desc_ready_i = 1'b1;
        desc_i = d;
        desc_valid_i = 1'b1;
        @(negedge clk);
        check("c_ready_idle", 64'(desc_ready_o), 64'(1));
        @(posedge clk); #1;
        desc_i = d2;
        @(negedge clk);
        check("c_valid1", 64'(desc_valid_o), 64'(1));
        check("c_desc1", 64'(desc_o), 64'(d));
        check("c_ready_send", 64'(desc_ready_o), 64'(1));
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
        @(negedge clk);
        check("c_valid2", 64'(desc_valid_o), 64'(1));
        check("c_desc2", 64'(desc_o), 64'(d2));
        @(posedge clk); #1;
        desc_ready_i = 1'b0;
        @(negedge clk);
        check("c_idle", 64'(desc_valid_o), 64'(0));
        check_writes(0, 64'h0, 8'h0, 4'h0);
        @(posedge clk); #1;

        // Early last on beat 3, missing last plus SLVERR on beat 7.
        d = mk(1'b1, 4'b0001, 32'h0000_0140);
        base = 64'hE000_0000_0000_0000;
        load_desc(d);
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                r_beat = '0;
                r_beat.data = base + 64'(k);
                r_beat.last = (k == 3);
                r_beat.resp = (k == 7) ? 2'b10 : 2'b00;
                r_valid = 1'b1;
            end else begin
                r_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 8) check("d_r_ready", 64'(r_ready), 64'(1));
            if (k > 0) begin
                check("d_last_err", 64'(last_err),
                      64'((k - 1 == 3) || (k - 1 == 7)));
                check("d_resp_err", 64'(resp_err), 64'(k - 1 == 7));
            end else begin
                check("d_errs_idle", 64'({resp_err, last_err}), 64'(0));
            end
            @(posedge clk); #1;
        end
        wait_desc_out(d);
        check_writes(8, base, 8'h05, 4'b0001);

        // Reset in the middle of a line, then a clean refill.
        way_ready = 1'b0;
        d = mk(1'b1, 4'b0010, 32'h0000_1240);
        load_desc(d);
        send_beats(64'h77, 4, -1);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("e_desc_ready", 64'(desc_ready_o), 64'(1));
        check("e_desc_valid", 64'(desc_valid_o), 64'(0));
        check("e_r_ready", 64'(r_ready), 64'(0));
        check("e_way_valid", 64'(way_valid), 64'(0));
        check("e_errs", 64'({resp_err, last_err}), 64'(0));
        check("e_desc_o", 64'(desc_o), 64'(0));
        way_ready = 1'b1;
        check_writes(0, 64'h0, 8'h0, 4'h0);
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
